// File: rtl/bit_demo_pkg.sv
// Shared types for the serial capture block: FSM state encoding and error-counter width.
package bit_demo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle clock-enable every 2**DIV_LOG2 cycles.
module tick_gen #(
  parameter int DIV_LOG2 = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [DIV_LOG2-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_LOG2'(1);
    end
  end

  assign tick = !clr && (r_cnt == '1);

endmodule

// File: rtl/serial_word_capture.sv
// Samples a synchronized serial stream on prescaled ticks and assembles WIDTH-bit words
// with a valid/ready output. Define PATTERN_CHECK_EN to add the alternating-complement checker.
module serial_word_capture
  import bit_demo_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ser_in,
  output logic [WIDTH-1:0]     word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy,
  output logic                 overrun
`ifdef PATTERN_CHECK_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sync1;
  logic               r_sync2;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_word;
  logic               r_valid;
  logic               r_overrun;
  logic               w_busy;
  logic               w_tick;
  logic               w_last;
  logic               w_done;
  logic               w_load_ok;
  logic [WIDTH-1:0]   w_shift_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ser_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (!en) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Prescaler is held clear in IDLE so the first tick lands a full period after entry.
  tick_gen #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!w_busy),
    .tick  (w_tick)
  );

  assign w_last      = (r_bitcnt == CNT_W'(WIDTH - 1));
  assign w_done      = w_busy && w_tick && w_last;
  assign w_load_ok   = !r_valid || word_ready;
  assign w_shift_nxt = {r_shreg[WIDTH-2:0], r_sync2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!w_busy) begin
        r_bitcnt <= '0;
        r_shreg  <= '0;
      end else if (w_tick) begin
        r_shreg  <= w_shift_nxt;
        r_bitcnt <= w_last ? '0 : r_bitcnt + CNT_W'(1);
      end
      // A completed word either replaces a consumed/empty slot or is dropped.
      if (w_done && w_load_ok) begin
        r_word  <= w_shift_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && word_ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_load_ok) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef PATTERN_CHECK_EN
  logic [ERR_CNT_W-1:0] r_err;
  logic                 r_have_prev;

  // Each accepted word should be the bitwise complement of the one accepted before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= '0;
      r_have_prev <= 1'b0;
    end else if (!w_busy) begin
      r_have_prev <= 1'b0;
    end else if (w_done && w_load_ok) begin
      r_have_prev <= 1'b1;
      if (r_have_prev && (w_shift_nxt != ~r_word) && (r_err != '1)) begin
        r_err <= r_err + ERR_CNT_W'(1);
      end
    end
  end

  assign err_cnt = r_err;
`endif

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign busy       = w_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_word_capture.sv
// Directed bench for serial_word_capture (WIDTH=4, DIV_LOG2=3) with a word scoreboard.
module tb_serial_word_capture;
  import bit_demo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ser_in = 1'b0;
  logic       word_ready = 1'b0;
  logic [3:0] word_out;
  logic       word_valid;
  logic       busy;
  logic       overrun;
`ifdef PATTERN_CHECK_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [3:0] sb_q[$];

  serial_word_capture #(
    .WIDTH    (4),
    .DIV_LOG2 (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ser_in     (ser_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef PATTERN_CHECK_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the handshake about to happen at the next rising edge, then advances to the next falling edge.
  task automatic step();
    logic [31:0] exp;
    if (word_valid && word_ready) begin
      exp = 'x;
      if (sb_q.size() > 0) exp = {28'd0, sb_q.pop_front()};
      chk("sb_word", {28'd0, word_out}, exp);
      pops++;
    end
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_in = bits[i];
      steps(8);
    end
  endtask

  initial begin
    int p0;
    logic [31:0] bits;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_word_out", {28'd0, word_out}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    steps(2);

    // First word 1011: valid exactly 33 clocks after en
    word_ready = 1'b0;
    en = 1'b1;
    ser_in = 1'b1;
    sb_q.push_back(4'b1011);
    bits = 32'b1011;
    for (int c = 1; c <= 33; c++) begin
      step();
      if (c % 8 == 0 && c < 32) ser_in = bits[3 - c / 8];
      if (c == 32) chk("lat_valid_c32", {31'd0, word_valid}, 32'd0);
    end
    chk("lat_valid_c33", {31'd0, word_valid}, 32'd1);
    chk("lat_word_c33", {28'd0, word_out}, 32'b1011);
    chk("busy_shift", {31'd0, busy}, 32'd1);
    en = 1'b0;
    word_ready = 1'b1;
    step();
    chk("consume_valid", {31'd0, word_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    steps(3);

    // Three back-to-back words with ready held high
    p0 = pops;
    en = 1'b1;
    sb_q.push_back(4'b1100);
    sb_q.push_back(4'b0011);
    sb_q.push_back(4'b1001);
    stream(32'b1100_0011_1001, 12);
    en = 1'b0;
    steps(2);
    chk("b2b_pops", pops - p0, 32'd3);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);
    steps(3);

    // Overrun: second word dropped while the first is held
    word_ready = 1'b0;
    en = 1'b1;
    sb_q.push_back(4'b0101);
    stream(32'b0101_1110, 8);
    en = 1'b0;
    step();
    chk("ovr_valid", {31'd0, word_valid}, 32'd1);
    chk("ovr_held", {28'd0, word_out}, 32'b0101);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    word_ready = 1'b1;
    step();
    chk("ovr_consumed", {31'd0, word_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    steps(3);

    // Partial word discarded when en falls after two ticks
    en = 1'b1;
    stream(32'b11, 2);
    step();
    en = 1'b0;
    steps(5);
    chk("partial_busy", {31'd0, busy}, 32'd0);
    chk("partial_novalid", {31'd0, word_valid}, 32'd0);
    p0 = pops;
    en = 1'b1;
    sb_q.push_back(4'b0110);
    stream(32'b0110, 4);
    en = 1'b0;
    steps(2);
    chk("partial_pops", pops - p0, 32'd1);
    steps(3);

    // Asynchronous reset mid-word with a word held
    word_ready = 1'b0;
    en = 1'b1;
    stream(32'b1001_11, 6);
    chk("prerst_valid", {31'd0, word_valid}, 32'd1);
    chk("prerst_word", {28'd0, word_out}, 32'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_word_out", {28'd0, word_out}, 32'd0);
    chk("arst_valid", {31'd0, word_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    steps(40);
    chk("postrst_valid", {31'd0, word_valid}, 32'd0);
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    p0 = pops;
    word_ready = 1'b1;
    en = 1'b1;
    sb_q.push_back(4'b0111);
    stream(32'b0111, 4);
    en = 1'b0;
    steps(2);
    chk("resume_pops", pops - p0, 32'd1);
    steps(3);

`ifdef PATTERN_CHECK_EN
    // Alternating-complement checker and saturation
    en = 1'b1;
    sb_q.push_back(4'b1010);
    sb_q.push_back(4'b0101);
    sb_q.push_back(4'b0111);
    stream(32'b1010_0101_0111, 12);
    en = 1'b0;
    steps(2);
    chk("pat_err1", {24'd0, err_cnt}, 32'd1);
    steps(3);
    en = 1'b1;
    ser_in = 1'b0;
    for (int w = 0; w < 300; w++) sb_q.push_back(4'b0000);
    steps(300 * 32);
    en = 1'b0;
    steps(2);
    chk("pat_sat", {24'd0, err_cnt}, 32'd255);
    steps(3);
`endif

    chk("sb_left", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
